// File: rtl/instr_cache.sv
// -----------------------------------------------------------------------------
// instr_cache
//   Direct-mapped, read-only instruction cache: 8 lines of 16 bytes (4 words),
//   3-bit tag, one valid bit per line. Hits are served combinationally in the
//   same cycle. A miss stalls the CPU, fetches the whole 16-byte block from
//   instruction memory and installs it in the line.
//
// Ports
//   CLK           in   1    CPU clock, rising edge
//   RESET         in   1    synchronous, active-high reset
//   PC_ADDRESS    in   10   byte address of requested instruction ([1:0] ignored)
//   INSTRUCTION   out  32   fetched word, meaningful only while BUSYWAIT=0
//   BUSYWAIT      out  1    1 = instruction not ready, CPU holds its PC
//   MEM_READ      out  1    block read request to instruction memory
//   MEM_ADDRESS   out  6    block address {tag, index}
//   MEM_READDATA  in   128  returned block, word 0 in [31:0]
//   MEM_BUSYWAIT  in   1    memory busy servicing the read
//   o_dbg_state   out  2    current FSM state (IDLE=0, FETCH=1, FILL=2)
//
// Handshake: the CPU side is a stall protocol -- the request is PC_ADDRESS and
// it completes in the cycle BUSYWAIT is 0. On the memory side MEM_READ is held
// with a stable MEM_ADDRESS; the read is done on the first edge where
// MEM_BUSYWAIT is low after having been high at least once, and MEM_READDATA
// is captured on that edge. There is no timeout.
// -----------------------------------------------------------------------------
module instr_cache (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [9:0]   PC_ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [7:0]     r_valid;
    logic [2:0]     r_tag  [8];
    logic [127:0]   r_data [8];

    logic [2:0]     r_lat_tag;
    logic [2:0]     r_lat_idx;
    logic           r_seen_busy;
    logic [127:0]   r_fill_data;
    logic [31:0]    r_instr_last;

    logic [2:0]     w_tag;
    logic [2:0]     w_idx;
    logic [1:0]     w_off;
    logic           w_hit;
    logic           w_lookup_hit;
    logic           w_mem_done;
    logic [31:0]    w_word;
    logic           w_unused_byte_bits;

    assign w_tag = PC_ADDRESS[9:7];
    assign w_idx = PC_ADDRESS[6:4];
    assign w_off = PC_ADDRESS[3:2];
    // Byte offset within the word is irrelevant to word-aligned fetches.
    assign w_unused_byte_bits = ^PC_ADDRESS[1:0];

    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lookup_hit = (r_state == IDLE) && w_hit;
    assign w_word       = r_data[w_idx][{w_off, 5'b00000} +: 32];

    // Completion needs a busy phase first, so a memory that has not yet
    // reacted to MEM_READ is not mistaken for a finished read.
    assign w_mem_done   = r_seen_busy && !MEM_BUSYWAIT;

    assign MEM_ADDRESS  = {r_lat_tag, r_lat_idx};
    assign o_dbg_state  = r_state;

    // Outside a hit the last delivered word is held.
    assign INSTRUCTION  = w_lookup_hit ? w_word : r_instr_last;

    always_comb begin
        w_next_state = r_state;
        BUSYWAIT     = 1'b1;
        MEM_READ     = 1'b0;
        case (r_state)
            IDLE: begin
                BUSYWAIT = !w_hit;
                if (!w_hit) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                MEM_READ = 1'b1;
                if (w_mem_done) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Control state: FSM, valid bits, latched miss address.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_lat_tag   <= '0;
            r_lat_idx   <= '0;
            r_seen_busy <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_lat_tag   <= w_tag;
                        r_lat_idx   <= w_idx;
                        r_seen_busy <= 1'b0;
                    end
                end
                FETCH: begin
                    if (MEM_BUSYWAIT) begin
                        r_seen_busy <= 1'b1;
                    end
                end
                FILL: begin
                    r_valid[r_lat_idx] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Data-path storage: not cleared by reset, but never written while
    // RESET is high so an abandoned refill leaves nothing behind.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == FETCH && w_mem_done) begin
                r_fill_data <= MEM_READDATA;
            end
            if (r_state == FILL) begin
                r_data[r_lat_idx] <= r_fill_data;
                r_tag[r_lat_idx]  <= r_lat_tag;
            end
            if (w_lookup_hit) begin
                r_instr_last <= w_word;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;

    logic         CLK;
    logic         RESET;
    logic [9:0]   PC_ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [1:0]   o_dbg_state;

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC_ADDRESS   (PC_ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- memory and reference model ----------------
    logic [127:0] mem_blk [64];
    int           mem_lat;
    int           mem_cnt;

    // Cache contents as the spec describes them: which block sits in each line.
    bit           m_valid [8];
    logic [2:0]   m_tag   [8];
    logic [31:0]  last_instr;
    bit           last_known;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; the memory responder reacts to the new state.
    // A read is busy for mem_lat cycles, then delivers the block.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (MEM_READ === 1'b1) begin
            if (mem_cnt < mem_lat) begin
                MEM_BUSYWAIT = 1'b1;
                mem_cnt++;
            end else begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = mem_blk[MEM_ADDRESS];
            end
        end else begin
            MEM_BUSYWAIT = 1'b0;
            mem_cnt      = 0;
            MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        clear_model();
        PC_ADDRESS = 10'h000;
        #1;
        check_eq("rst_mem_read", MEM_READ, 1'b0);
        check_eq("rst_mem_addr", MEM_ADDRESS, 6'h00);
        check_eq("rst_state", o_dbg_state, 2'd0);
        check_eq("rst_first_miss", BUSYWAIT, 1'b1);
    endtask

    // One CPU fetch: look up, stall through any refill, check the delivered word.
    task automatic access(input logic [9:0] a, input int lat);
        logic [5:0] blk;
        bit         miss;
        int         stall;
        blk     = a[9:4];
        mem_lat = lat;
        PC_ADDRESS = a;
        #1;
        miss = !(m_valid[blk[2:0]] && (m_tag[blk[2:0]] == blk[5:3]));
        check_eq("lookup_busy", BUSYWAIT, miss);
        if (miss && last_known) check_eq("instr_hold", INSTRUCTION, last_instr);
        stall = 0;
        while (BUSYWAIT === 1'b1 && stall < 100) begin
            if (MEM_READ === 1'b1) check_eq("mem_addr", MEM_ADDRESS, blk);
            tick();
            stall++;
        end
        // Miss cycle + busy memory cycles + completion cycle + one fill cycle.
        if (miss) check_eq("stall_cycles", stall, lat + 3);
        check_eq("busy_release", BUSYWAIT, 1'b0);
        check_eq("instr", INSTRUCTION, mem_blk[blk][a[3:2]*32 +: 32]);
        check_eq("mem_read_idle", MEM_READ, 1'b0);
        m_valid[blk[2:0]] = 1'b1;
        m_tag[blk[2:0]]   = blk[5:3];
        last_instr = mem_blk[blk][a[3:2]*32 +: 32];
        last_known = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET        = 1'b1;
        PC_ADDRESS   = '0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        mem_lat      = 1;
        mem_cnt      = 0;
        last_instr   = '0;
        last_known   = 1'b0;
        for (int i = 0; i < 64; i++) mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
        clear_model();

        do_reset();

        // Cold miss on block 0, then sequential hits in the same block.
        access(10'h000, 5);
        access(10'h004, 2);
        access(10'h008, 2);
        access(10'h00C, 2);

        // Conflict on index 0, then the evicted block misses again.
        access(10'h080, 3);
        access(10'h000, 1);

        // Address change while the refill of 0x010 is in progress.
        begin
            int lat;
            lat = 3;
            mem_lat = lat;
            PC_ADDRESS = 10'h010;
            #1;
            check_eq("sw_miss", BUSYWAIT, 1'b1);
            tick();
            PC_ADDRESS = 10'h020;
            #1;
            for (int i = 0; i <= lat; i++) begin
                check_eq("sw_fetch_read", MEM_READ, 1'b1);
                check_eq("sw_fetch_addr", MEM_ADDRESS, 6'h01);
                tick();
            end
            check_eq("sw_fill_read", MEM_READ, 1'b0);
            check_eq("sw_fill_busy", BUSYWAIT, 1'b1);
            tick();
            m_valid[1] = 1'b1;
            m_tag[1]   = 3'd0;
            check_eq("sw_new_miss", BUSYWAIT, 1'b1);
            access(10'h020, 2);
            access(10'h014, 1);
        end

        // Reset pulsed while fetching 0x030.
        mem_lat = 4;
        PC_ADDRESS = 10'h030;
        #1;
        check_eq("rm_miss", BUSYWAIT, 1'b1);
        tick();
        check_eq("rm_read", MEM_READ, 1'b1);
        check_eq("rm_addr", MEM_ADDRESS, 6'h03);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        clear_model();
        #1;
        check_eq("rm_read_drop", MEM_READ, 1'b0);
        check_eq("rm_state", o_dbg_state, 2'd0);
        check_eq("rm_addr_clr", MEM_ADDRESS, 6'h00);
        access(10'h030, 2);

        // Last word of the last block.
        access(10'h3FC, 4);
        access(10'h3F0, 1);

        // Random traffic over a small tag range so hits and conflicts both occur.
        for (int n = 0; n < 150; n++) begin
            logic [2:0] t;
            logic [2:0] ix;
            logic [1:0] off;
            logic [1:0] bb;
            t   = 3'($urandom_range(0, 2));
            ix  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            bb  = 2'($urandom_range(0, 3));
            access({t, ix, off, bb}, $urandom_range(1, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
